// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out transmitter
// and its matching receiver.
package piso_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   // Ceiling log2: the number of bits needed to count 0..v-1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Counter width with a one-bit floor, so that v=1 still gives a real register.
   function automatic int cnt_width(input int v);
      return (clog2(v) < 1) ? 1 : clog2(v);
   endfunction

endpackage

// File: rtl/piso_bit_timer.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the last
// clock of each serial bit with a one-cycle tick.
module bit_timer
   import piso_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            DW   = cnt_width(DIV);
   localparam logic [DW-1:0] LAST = DW'(DIV - 1);

   logic [DW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/piso_tx.sv
// Frame transmitter: start bit, W data bits LSB first, stop bit, each held
// DIV clocks; BUSY covers the frame and DONE pulses once at its end.
module piso_tx
   import piso_pkg::*;
#(
   parameter int W   = 4,
   parameter int DIV = 4
) (
   input  logic         C,
   input  logic         sR,
   input  logic [W-1:0] D,
   input  logic         L,
   output logic         TX,
   output logic         BUSY,
   output logic         DONE,
   output state_t       dbg_state
);

   // Handshake: L is the request and BUSY=0 is ready; a word is taken on any
   // edge where L=1 and BUSY=0. Requests seen while BUSY=1 are dropped.

   localparam int            BW       = cnt_width(W);
   localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

   state_t        state;
   logic [W-1:0]  shift;
   logic [W-1:0]  shift_nx;
   logic [BW-1:0] bitcnt;
   logic          tick;

   assign shift_nx  = shift >> 1;
   assign dbg_state = state;

   // The divider is held cleared in IDLE so the start bit begins at count 0.
   bit_timer #(.DIV(DIV)) u_timer (
      .clk  (C),
      .rst  (sR),
      .clr  (state == IDLE),
      .en   (state != IDLE),
      .tick (tick)
   );

   always_ff @(posedge C) begin
      if (sR) begin
         state  <= IDLE;
         TX     <= LINE_IDLE;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
         bitcnt <= '0;
         shift  <= '0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               TX <= LINE_IDLE;
               if (L) begin
                  shift  <= D;
                  bitcnt <= '0;
                  TX     <= START_LVL;
                  BUSY   <= 1'b1;
                  state  <= START;
               end
            end
            START: begin
               if (tick) begin
                  TX    <= shift[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  shift <= shift_nx;
                  if (bitcnt == LAST_BIT) begin
                     TX    <= STOP_LVL;
                     state <= STOP;
                  end else begin
                     TX     <= shift_nx[0];
                     bitcnt <= bitcnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: directed table, multi-cycle corner sequences, and
// randomized traffic checked against a timing-rule reference model.
module tb_piso_tx;
   import piso_pkg::*;

   localparam int W     = 4;
   localparam int DIV   = 4;
   localparam int FRAME = (W + 2) * DIV;

   // clock / reset
   logic C;
   initial C = 1'b0;
   always #5 C = ~C;

   logic         sr, l, tx, busy, done;
   logic [W-1:0] d;
   state_t       st;
   logic         sr1, l1, tx1, busy1, done1;
   logic [W-1:0] d1;
   state_t       st1;

   piso_tx #(.W(W), .DIV(DIV)) dut (
      .C(C), .sR(sr), .D(d), .L(l), .TX(tx), .BUSY(busy), .DONE(done), .dbg_state(st)
   );

   piso_tx #(.W(W), .DIV(1)) dut1 (
      .C(C), .sR(sr1), .D(d1), .L(l1), .TX(tx1), .BUSY(busy1), .DONE(done1), .dbg_state(st1)
   );

   int total = 0;
   int bad   = 0;

   // reference model: one active frame described by its accept edge and word
   logic [2:0]   exp_q[$];
   int           n = 0;
   bit           m_act = 0;
   int           m_k = 0;
   logic [W-1:0] m_d = '0;

   task automatic model_edge(input logic li, input logic [W-1:0] di, input logic ri);
      int t, idx;
      logic [2:0] e;
      e = 3'b100;
      if (ri) begin
         m_act = 0;
      end else begin
         if (!m_act && li) begin
            m_act = 1;
            m_k   = n;
            m_d   = di;
         end
         if (m_act) begin
            t = n - m_k;
            if (t == FRAME) begin
               m_act = 0;
               e     = 3'b101;
            end else begin
               idx = t / DIV;
               if (idx == 0)      e = 3'b010;
               else if (idx <= W) e = {m_d[idx-1], 2'b10};
               else               e = 3'b110;
            end
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic check(input string nm, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   // driver: one clock on the main DUT, compared against the model
   task automatic step(input logic li, input logic [W-1:0] di, input logic ri);
      logic [2:0] e;
      l  = li;
      d  = di;
      sr = ri;
      @(posedge C);
      model_edge(li, di, ri);
      #1;
      e = exp_q.pop_front();
      total++;
      if ({tx, busy, done} !== e) begin
         bad++;
         $display("FAIL model edge=%0d got tx/busy/done=%b exp=%b", n, {tx, busy, done}, e);
      end
      n++;
   endtask

   task automatic step1(input logic li, input logic [W-1:0] di, input logic ri);
      l1  = li;
      d1  = di;
      sr1 = ri;
      @(posedge C);
      #1;
   endtask

   typedef struct {
      logic         l;
      logic [W-1:0] d;
      logic         r;
      int           cyc;
      logic [2:0]   e;   // {TX, BUSY, DONE}
   } row_t;

   row_t tbl[12];
   int   starts[$];
   int   dones[$];
   bit   prev_busy;

   initial begin
      logic [W-1:0] exp1[6];

      // reset idle, one 1011 frame, ignored load at edge 10, drain
      tbl[0]  = '{1'b1, 4'hF,    1'b1, 3, 3'b100};
      tbl[1]  = '{1'b1, 4'b1011, 1'b0, 1, 3'b010};
      tbl[2]  = '{1'b0, 4'b0000, 1'b0, 3, 3'b010};
      tbl[3]  = '{1'b0, 4'b0000, 1'b0, 4, 3'b110};
      tbl[4]  = '{1'b0, 4'b0000, 1'b0, 2, 3'b110};
      tbl[5]  = '{1'b1, 4'b0000, 1'b0, 1, 3'b110};
      tbl[6]  = '{1'b0, 4'b0000, 1'b0, 1, 3'b110};
      tbl[7]  = '{1'b0, 4'b0000, 1'b0, 4, 3'b010};
      tbl[8]  = '{1'b0, 4'b0000, 1'b0, 4, 3'b110};
      tbl[9]  = '{1'b0, 4'b0000, 1'b0, 4, 3'b110};
      tbl[10] = '{1'b0, 4'b0000, 1'b0, 1, 3'b101};
      tbl[11] = '{1'b0, 4'b0000, 1'b0, 3, 3'b100};

      sr = 1'b1; l = 1'b0; d = '0;
      sr1 = 1'b1; l1 = 1'b0; d1 = '0;

      for (int i = 0; i < 12; i++) begin
         for (int j = 0; j < tbl[i].cyc; j++) begin
            step(tbl[i].l, tbl[i].d, tbl[i].r);
            check($sformatf("tbl row%0d cyc%0d", i, j), int'({tx, busy, done}), int'(tbl[i].e));
         end
         if (i == 0) check("reset state idle", int'(st), int'(IDLE));
      end

      // back-to-back with L held high
      prev_busy = busy;
      for (int i = 0; i < 3 * (FRAME + 1); i++) begin
         step(1'b1, 4'b0110, 1'b0);
         if (busy && !prev_busy) starts.push_back(i);
         if (done) dones.push_back(i);
         if (i == FRAME + 1 - 1) check("b2b gap tx", int'(tx), 1);
         prev_busy = busy;
      end
      step(1'b0, 4'b0000, 1'b0);
      check("b2b starts", starts.size(), 3);
      check("b2b dones", dones.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < starts.size()) check($sformatf("b2b start%0d", i), starts[i], i * (FRAME + 1));
         if (i < dones.size())  check($sformatf("b2b done%0d", i), dones[i], i * (FRAME + 1) + FRAME);
      end

      // mid-frame reset, then a clean frame from edge 12
      dones.delete();
      for (int i = 0; i < 12 + FRAME + 3; i++) begin
         step(i == 0 || i == 12, (i == 12) ? 4'b0101 : 4'b1111, i == 9);
         if (i == 9) check("midreset tx/busy", int'({tx, busy}), 2);
         if (i == 12) check("restart state", int'(st), int'(START));
         if (done) dones.push_back(i);
      end
      check("midreset dones", dones.size(), 1);
      if (dones.size() > 0) check("midreset done edge", dones[0], 12 + FRAME);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) == 0, W'($urandom), $urandom_range(0, 79) == 0);
      end
      step(1'b1, 4'b0000, 1'b1);
      check("rand reset wins", int'(st), int'(IDLE));

      // DIV=1 instance: 1001 -> 0,1,0,0,1,1 then DONE
      exp1[0] = 0; exp1[1] = 1; exp1[2] = 0; exp1[3] = 0; exp1[4] = 1; exp1[5] = 1;
      step1(1'b1, 4'hF, 1'b1);
      check("div1 reset", int'({tx1, busy1, done1}), 4);
      step1(1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step1(i == 0, (i == 0) ? 4'b1001 : 4'b0000, 1'b0);
         check($sformatf("div1 bit%0d", i), int'({tx1, busy1, done1}), int'({exp1[i][0], 2'b10}));
      end
      step1(1'b0, 4'h0, 1'b0);
      check("div1 done", int'({tx1, busy1, done1}), 5);
      step1(1'b0, 4'h0, 1'b0);
      check("div1 done once", int'(done1), 0);

      dones.delete();
      for (int i = 0; i < 21; i++) begin
         step1(1'b1, 4'b0110, 1'b0);
         if (done1) dones.push_back(i);
      end
      check("div1 b2b dones", dones.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < dones.size()) check($sformatf("div1 b2b done%0d", i), dones[i], 6 + 7 * i);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
